sw_result_packer: RTL and testbench

Downstream stage of the Smith-Waterman core. Captures the per-cycle traceback symbol stream (`query_seq_out`, `database_seq_out`, `score`, `output_valid`) into a LIFO. Traceback emits the alignment end-to-start, so the block re-emits it start-to-end, packed `PACK` symbol pairs per word, over a valid/ready output handshake. The core has no backpressure input; this block must therefore accept every beat the core presents while collecting.

---
 rtl/sw_pkg.sv | 30 +++
 rtl/sw_align_lifo.sv | 60 ++++++
 rtl/sw_result_packer.sv | 187 ++++++++++++++++++
 tb/tb_sw_result_packer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared Smith-Waterman definitions: letter widths, symbol encodings,
// symbol-pair layout and the result packer state encoding.
// Contents: LETTER_WIDTH, SCORE_WIDTH, SYM_WIDTH, GAP_BIT, SYM_* codes,
//           sw_pair_t, sw_pack_state_t.
package sw_pkg;

  localparam int LETTER_WIDTH = 2;
  localparam int SCORE_WIDTH  = 10;
  localparam int SYM_WIDTH    = LETTER_WIDTH + 1;
  localparam int GAP_BIT      = LETTER_WIDTH;

  localparam logic [SYM_WIDTH-1:0] SYM_A   = 3'b000;
  localparam logic [SYM_WIDTH-1:0] SYM_C   = 3'b001;
  localparam logic [SYM_WIDTH-1:0] SYM_G   = 3'b010;
  localparam logic [SYM_WIDTH-1:0] SYM_T   = 3'b011;
  localparam logic [SYM_WIDTH-1:0] SYM_GAP = 3'b100;

  // One traceback position: query symbol in the upper half.
  typedef struct packed {
    logic [SYM_WIDTH-1:0] query;
    logic [SYM_WIDTH-1:0] database;
  } sw_pair_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } sw_pack_state_t;

endpackage

// File: rtl/sw_align_lifo.sv
// Register-array stack of symbol pairs with single push and multi-pop.
// Latency: push/pop take effect on the next edge; the top PACK entries are read combinationally.
// Backpressure: none; a push while full is discarded, the caller tracks the loss.
// Ports: clk, rst (async, active-high); push/push_dat; pop/pop_n (entries removed,
//        must not exceed count); count, full; top_dat[i] = i-th entry from the top
//        (zero where i >= count).
module sw_align_lifo import sw_pkg::*; #(
  parameter int DATA_W = $bits(sw_pair_t),
  parameter int DEPTH  = 64,
  parameter int PACK   = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = $clog2(PACK + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_dat,
  input  logic                         pop,
  input  logic [PW-1:0]                pop_n,
  output logic [CW-1:0]                count,
  output logic                         full,
  output logic [PACK-1:0][DATA_W-1:0]  top_dat
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign full = (count == CW'(DEPTH));

  // Pop has priority; the packer never pushes and pops in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (pop) begin
      count <= count - CW'(pop_n);
    end else if (push && !full) begin
      count <= count + 1'b1;
    end
  end

  // Storage needs no reset: reads beyond count are masked to zero.
  always_ff @(posedge clk) begin
    if (push && !full && !pop) begin
      mem[count[AW-1:0]] <= push_dat;
    end
  end

  always_comb begin
    int idx;
    idx     = 0;
    top_dat = '0;
    for (int i = 0; i < PACK; i++) begin
      idx = int'(count) - 1 - i;
      if (idx >= 0) begin
        top_dat[i] = mem[idx[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/sw_result_packer.sv
// Captures the traceback symbol stream into a LIFO and re-emits it start-to-end, PACK pairs per word.
// Latency: out_valid rises on the edge that accepts the in_last beat; one word per cycle after that.
// Backpressure: out_ready stalls emission with all outputs held; input beats are never stalled (dropped when full or emitting).
// Ports: clk, rst (async, active-high); in_valid/in_last/query_sym_in/database_sym_in/score_in
//        from the core; busy; out_valid/out_ready handshake with out_query_word, out_db_word,
//        out_keep, out_last, out_score, out_len; drop (sticky discard flag).
// Optional: define SW_PACK_STATS_EN to add out_gaps and out_mismatches pair counters.
module sw_result_packer #(
  parameter int LETTER_WIDTH  = sw_pkg::LETTER_WIDTH,
  parameter int SCORE_WIDTH   = sw_pkg::SCORE_WIDTH,
  parameter int MAX_ALIGN_LEN = 64,
  parameter int PACK          = 4,
  localparam int SYM_W        = LETTER_WIDTH + 1,
  localparam int CW           = $clog2(MAX_ALIGN_LEN + 1),
  localparam int KW           = $clog2(PACK + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic [SYM_W-1:0]        query_sym_in,
  input  logic [SYM_W-1:0]        database_sym_in,
  input  logic [SCORE_WIDTH-1:0]  score_in,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PACK*SYM_W-1:0]   out_query_word,
  output logic [PACK*SYM_W-1:0]   out_db_word,
  output logic [KW-1:0]           out_keep,
  output logic                    out_last,
  output logic [SCORE_WIDTH-1:0]  out_score,
  output logic [CW-1:0]           out_len,
`ifdef SW_PACK_STATS_EN
  output logic [CW-1:0]           out_gaps,
  output logic [CW-1:0]           out_mismatches,
`endif
  output logic                    drop
);

  import sw_pkg::*;

  localparam int GAP_IDX = LETTER_WIDTH;

  sw_pack_state_t                  state_q;
  logic                            busy_q;
  logic                            out_valid_q;
  logic                            drop_q;
  logic [SCORE_WIDTH-1:0]          score_q;
  logic [CW-1:0]                   len_q;

  logic                            push;
  logic                            push_ok;
  logic                            pop;
  logic                            full;
  logic [CW-1:0]                   count;
  logic [CW-1:0]                   len_nxt;
  logic [KW-1:0]                   keep;
  logic [PACK-1:0][2*SYM_W-1:0]    top_dat;

  // Beats are only stored outside EMIT; a full stack silently discards.
  assign push    = in_valid && (state_q != EMIT);
  assign push_ok = push && !full;
  assign len_nxt = count + CW'(push_ok);
  assign pop     = out_valid_q && out_ready;

  sw_align_lifo #(
    .DATA_W (2 * SYM_W),
    .DEPTH  (MAX_ALIGN_LEN),
    .PACK   (PACK)
  ) u_lifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat ({query_sym_in, database_sym_in}),
    .pop      (pop),
    .pop_n    (keep),
    .count    (count),
    .full     (full),
    .top_dat  (top_dat)
  );

  // Word lanes come straight from the stack top, so they only change on a pop
  // and hold naturally during a stall. Lane 0 is the most recent push, which is
  // the earliest alignment position.
  always_comb begin
    keep           = '0;
    out_query_word = '0;
    out_db_word    = '0;
    if (out_valid_q) begin
      keep = (count < CW'(PACK)) ? KW'(count) : KW'(PACK);
      for (int i = 0; i < PACK; i++) begin
        if (KW'(i) < keep) begin
          out_query_word[i*SYM_W +: SYM_W] = top_dat[i][2*SYM_W-1:SYM_W];
          out_db_word[i*SYM_W +: SYM_W]    = top_dat[i][SYM_W-1:0];
        end
      end
    end
  end

  assign out_keep  = keep;
  assign out_last  = out_valid_q && (count <= CW'(PACK));
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign drop      = drop_q;
  assign out_score = score_q;
  assign out_len   = len_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      drop_q      <= 1'b0;
      score_q     <= '0;
      len_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            score_q <= score_in;
            drop_q  <= 1'b0;
            busy_q  <= 1'b1;
            if (in_last) begin
              state_q     <= EMIT;
              out_valid_q <= 1'b1;
              len_q       <= len_nxt;
            end else begin
              state_q <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (in_valid) begin
            if (full) begin
              drop_q <= 1'b1;
            end
            if (in_last) begin
              state_q     <= EMIT;
              out_valid_q <= 1'b1;
              len_q       <= len_nxt;
            end
          end
        end
        EMIT: begin
          if (in_valid) begin
            drop_q <= 1'b1;
          end
          if (out_valid_q && out_ready && out_last) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

`ifdef SW_PACK_STATS_EN
  logic pair_gap;
  logic pair_mis;

  assign pair_gap = query_sym_in[GAP_IDX] | database_sym_in[GAP_IDX];
  assign pair_mis = !pair_gap && (query_sym_in != database_sym_in);

  // Counters restart on the first beat and only count pairs actually stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_gaps       <= '0;
      out_mismatches <= '0;
    end else if (state_q == IDLE && in_valid) begin
      out_gaps       <= CW'(pair_gap);
      out_mismatches <= CW'(pair_mis);
    end else if (state_q == COLLECT && push_ok) begin
      out_gaps       <= out_gaps + CW'(pair_gap);
      out_mismatches <= out_mismatches + CW'(pair_mis);
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_sw_result_packer.sv
// Bench for sw_result_packer: directed and random alignments against a queue
// model that stores the pushed pairs and derives the emitted words by reversal.
module tb_sw_result_packer;
  import sw_pkg::*;

  localparam int MAXL = 64;
  localparam int PK   = 4;
  localparam int SYMW = 3;
  localparam int CW   = 7;
  localparam int KW   = 3;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_last;
  logic [SYMW-1:0]   query_sym_in;
  logic [SYMW-1:0]   database_sym_in;
  logic [9:0]        score_in;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [PK*SYMW-1:0] out_query_word;
  logic [PK*SYMW-1:0] out_db_word;
  logic [KW-1:0]     out_keep;
  logic              out_last;
  logic [9:0]        out_score;
  logic [CW-1:0]     out_len;
  logic              drop;
`ifdef SW_PACK_STATS_EN
  logic [CW-1:0]     out_gaps;
  logic [CW-1:0]     out_mismatches;
`endif

  sw_result_packer #(
    .LETTER_WIDTH  (2),
    .SCORE_WIDTH   (10),
    .MAX_ALIGN_LEN (MAXL),
    .PACK          (PK)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_last         (in_last),
    .query_sym_in    (query_sym_in),
    .database_sym_in (database_sym_in),
    .score_in        (score_in),
    .busy            (busy),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_query_word  (out_query_word),
    .out_db_word     (out_db_word),
    .out_keep        (out_keep),
    .out_last        (out_last),
    .out_score       (out_score),
    .out_len         (out_len),
`ifdef SW_PACK_STATS_EN
    .out_gaps        (out_gaps),
    .out_mismatches  (out_mismatches),
`endif
    .drop            (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  logic [SYMW-1:0] mq[$];
  logic [SYMW-1:0] md[$];
  bit              m_drop  = 1'b0;
  int unsigned     m_score = 0;
  bit              m_first = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SYMW-1:0] rsym();
    int unsigned r;
    r = $urandom_range(0, 4);
    return (r == 4) ? SYM_GAP : SYMW'(r);
  endfunction

  function automatic void model_reset();
    mq.delete();
    md.delete();
    m_drop  = 1'b0;
    m_first = 1'b1;
  endfunction

  // One beat driven at posedge+1, held across one rising edge.
  task automatic beat(input logic [SYMW-1:0] q, input logic [SYMW-1:0] d,
                      input bit last, input int unsigned sc);
    in_valid        = 1'b1;
    in_last         = last;
    query_sym_in    = q;
    database_sym_in = d;
    score_in        = 10'(sc);
    if (m_first) begin
      mq.delete();
      md.delete();
      m_drop  = 1'b0;
      m_score = sc & 32'h3FF;
      m_first = 1'b0;
    end
    if (mq.size() < MAXL) begin
      mq.push_back(q);
      md.push_back(d);
    end else begin
      m_drop = 1'b1;
    end
    if (last) m_first = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    score_in = 10'($urandom);
  endtask

  task automatic send_align(input int n, input int unsigned sc);
    for (int k = 0; k < n; k++) begin
      beat(rsym(), rsym(), (k == n - 1), (k == 0) ? sc : $urandom);
      if (k == 0 && n > 1) begin
        chk("collect_no_valid", out_valid, 1'b0);
        chk("collect_busy", busy, 1'b1);
      end
    end
    chk("first_word_latency", out_valid, 1'b1);
  endtask

  // Consume every word of the current alignment and check it against the model.
  task automatic drain(input bit stall);
    int n;
    int nw;
    int cyc;
    int rem;
    logic [PK*SYMW-1:0] eq;
    logic [PK*SYMW-1:0] ed;
    n  = mq.size();
    nw = (n + PK - 1) / PK;
    for (int w = 0; w < nw; w++) begin
      if (w == 0) begin
        cyc = 0;
        while (!out_valid && cyc < 50) begin
          @(posedge clk);
          #1;
          cyc++;
        end
        chk("drop_flag", drop, m_drop);
      end
      chk("word_valid", out_valid, 1'b1);
      eq  = '0;
      ed  = '0;
      rem = n - w * PK;
      for (int i = 0; i < PK; i++) begin
        if (w * PK + i < n) begin
          eq[i*SYMW +: SYMW] = mq[n - 1 - (w * PK + i)];
          ed[i*SYMW +: SYMW] = md[n - 1 - (w * PK + i)];
        end
      end
      chk("query_word", out_query_word, eq);
      chk("db_word", out_db_word, ed);
      chk("keep", out_keep, (rem < PK) ? rem : PK);
      chk("last", out_last, (rem <= PK));
      chk("score", out_score, m_score);
      chk("len", out_len, n);
      if (stall && w == 0) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(posedge clk);
          #1;
          chk("stall_valid", out_valid, 1'b1);
          chk("stall_query", out_query_word, eq);
          chk("stall_db", out_db_word, ed);
          chk("stall_keep", out_keep, (rem < PK) ? rem : PK);
        end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("done_busy", busy, 1'b0);
    chk("done_valid", out_valid, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    in_valid        = 1'b0;
    in_last         = 1'b0;
    query_sym_in    = '0;
    database_sym_in = '0;
    score_in        = '0;
    out_ready       = 1'b0;
    #17;
    // Reset state
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_drop", drop, 1'b0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_keep", out_keep, 0);
    chk("rst_len", out_len, 0);
    chk("rst_score", out_score, 0);
    chk("rst_qword", out_query_word, 0);
    chk("rst_dword", out_db_word, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_reset();

    // Single word: T/T, G/G, C/-, A/A
    out_ready = 1'b1;
    beat(SYM_T, SYM_T, 1'b0, 5);
    beat(SYM_G, SYM_G, 1'b0, 77);
    beat(SYM_C, SYM_GAP, 1'b0, 99);
    beat(SYM_A, SYM_A, 1'b1, 3);
    chk("tp_query", out_query_word, 12'h688);
    chk("tp_db", out_db_word, 12'h6A0);
    chk("tp_keep", out_keep, 4);
    chk("tp_last", out_last, 1'b1);
    chk("tp_len", out_len, 4);
    chk("tp_score", out_score, 5);
    drain(1'b0);

    // Two words of 6 pairs
    send_align(6, $urandom_range(0, 1023));
    drain(1'b0);

    // Backpressure on a 7-pair alignment
    out_ready = 1'b0;
    send_align(7, $urandom_range(0, 1023));
    drain(1'b1);

    // Single-beat alignment
    send_align(1, 321);
    drain(1'b0);

    // Exactly full: no drop
    send_align(MAXL, 17);
    drain(1'b0);

    // Overflow
    send_align(MAXL + 3, 900);
    chk("ovf_drop", drop, 1'b1);
    drain(1'b0);
    chk("ovf_drop_sticky", drop, 1'b1);
    beat(rsym(), rsym(), 1'b0, 44);
    chk("ovf_drop_clear", drop, 1'b0);
    for (int k = 0; k < 4; k++) beat(rsym(), rsym(), (k == 3), $urandom);
    drain(1'b0);

    // Beat during EMIT
    out_ready = 1'b0;
    send_align(5, 222);
    in_valid        = 1'b1;
    query_sym_in    = rsym();
    database_sym_in = rsym();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    m_drop   = 1'b1;
    chk("emit_beat_drop", drop, 1'b1);
    drain(1'b0);

    // Reset mid-EMIT
    send_align(6, 400);
    chk("mid_keep0", out_keep, 4);
    @(posedge clk);
    #1;
    chk("mid_second_valid", out_valid, 1'b1);
    chk("mid_second_keep", out_keep, 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_keep", out_keep, 0);
    #2;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    send_align(4, 611);
    drain(1'b0);

    // Random alignments, random stall
    for (int t = 0; t < 10; t++) begin
      out_ready = $urandom_range(0, 1) != 0;
      send_align($urandom_range(1, 20), $urandom_range(0, 1023));
      drain($urandom_range(0, 1) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
